window_gen_3x3: RTL and testbench

- Upstream feeder for the 3x3 corner-test stage.
- Accepts a raster-order pixel stream, one 8-bit pixel per valid cycle, and buffers the two previous image rows.
- Each accepted pixel that completes a full 3x3 neighbourhood produces one registered window: three 24-bit row words plus the centre coordinates.
- The output row-word byte layout matches the corner-test input exactly, so the two stages connect directly.

---
 rtl/window_gen_3x3_pkg.sv | 21 ++
 rtl/window_gen_3x3_line_buffer.sv | 22 ++
 rtl/window_gen_3x3.sv | 83 ++++++++
 tb/tb_window_gen_3x3.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/window_gen_3x3_pkg.sv
// Shared types and constants for the 3x3 window generator and the corner-test stage.
// A row word packs three pixels of one image row: left, centre and right, from low byte to high byte.
package window_gen_3x3_pkg;
    localparam int PIX_W      = 8;
    localparam int ROW_WORD_W = 24;
    localparam int LANE_L     = 0;
    localparam int LANE_C     = 1;
    localparam int LANE_R     = 2;

    typedef struct packed {
        logic [ROW_WORD_W-1:0] top;
        logic [ROW_WORD_W-1:0] mid;
        logic [ROW_WORD_W-1:0] btm;
    } win3_t;

    // The new pixel enters the right lane; the left lane drops out.
    function automatic logic [ROW_WORD_W-1:0] shift_in(input logic [ROW_WORD_W-1:0] w,
                                                       input logic [PIX_W-1:0] p);
        return {p, w[ROW_WORD_W-1:(LANE_C*PIX_W)]};
    endfunction
endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One image row of pixel storage.
// The read is asynchronous, so a read in the same cycle as a write returns the old pixel.
module line_buffer
    import window_gen_3x3_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/window_gen_3x3.sv
// Raster-stream to 3x3 window generator that feeds the corner-test stage.
// Two line buffers hold the previous two rows. A window is emitted only for interior centres.
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10,
    parameter int RW    = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PIX_W-1:0]      pix_in,
    input  logic                  pix_valid,
    input  logic                  frame_start,
    output logic [ROW_WORD_W-1:0] win_top,
    output logic [ROW_WORD_W-1:0] win_mid,
    output logic [ROW_WORD_W-1:0] win_btm,
    output logic                  win_valid,
    output logic [CW-1:0]         win_x,
    output logic [RW-1:0]         win_y,
    output logic                  frame_done
);
    logic [CW-1:0]    col, cur_col;
    logic [RW-1:0]    row, cur_row;
    logic [PIX_W-1:0] lb1_rd, lb2_rd;
    logic             last_col, last_row, win_hit;
    win3_t            sr, sr_nxt;

    // A frame_start pixel takes position (0,0) in the same cycle, so it must override the counters.
    always_comb begin
        cur_col    = (pix_valid && frame_start) ? '0 : col;
        cur_row    = (pix_valid && frame_start) ? '0 : row;
        last_col   = (cur_col == CW'(IMG_W - 1));
        last_row   = (cur_row == RW'(IMG_H - 1));
        win_hit    = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
        sr_nxt.top = shift_in(sr.top, lb2_rd);
        sr_nxt.mid = shift_in(sr.mid, lb1_rd);
        sr_nxt.btm = shift_in(sr.btm, pix_in);
    end

    line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk(clk), .we(pix_valid), .addr(cur_col), .wdata(pix_in), .rdata(lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb2 (
        .clk(clk), .we(pix_valid), .addr(cur_col), .wdata(lb1_rd), .rdata(lb2_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            sr         <= '0;
            win_top    <= '0;
            win_mid    <= '0;
            win_btm    <= '0;
            win_x      <= '0;
            win_y      <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                sr  <= sr_nxt;
                col <= last_col ? '0 : cur_col + CW'(1);
                if (last_col) row <= last_row ? '0 : cur_row + RW'(1);
                else          row <= cur_row;
                // Border pixels still feed the shift registers, but no window is exposed for them.
                if (win_hit) begin
                    win_valid  <= 1'b1;
                    win_top    <= sr_nxt.top;
                    win_mid    <= sr_nxt.mid;
                    win_btm    <= sr_nxt.btm;
                    win_x      <= cur_col - CW'(1);
                    win_y      <= cur_row - RW'(1);
                    frame_done <= last_col && last_row;
                end
            end
        end
    end
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on an 8x6 image: a frame-array reference model checked every cycle,
// plus literal expectations at chosen points of each directed scenario and a random phase.
module tb_window_gen_3x3;
    localparam int W = 8, H = 6, CW = 3, RW = 3;

    logic          clk = 0, rst_n = 0, pix_valid = 0, frame_start = 0;
    logic [7:0]    pix_in = 0;
    logic [23:0]   win_top, win_mid, win_btm;
    logic          win_valid, frame_done;
    logic [CW-1:0] win_x;
    logic [RW-1:0] win_y;

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .frame_start(frame_start), .win_top(win_top), .win_mid(win_mid),
        .win_btm(win_btm), .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, nwin = 0;
    bit cmp_en = 0;

    // Reference model: the current frame as a 2D image, plus the expected registered outputs.
    int          mx = 0, my = 0;
    logic [7:0]  img [H][W];
    logic [23:0] e_top = 0, e_mid = 0, e_btm = 0;
    logic        e_valid = 0, e_done = 0;
    int          e_x = 0, e_y = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input bit fs, input logic [7:0] p);
        int x, y;
        e_valid = 0; e_done = 0;
        if (!r) begin
            mx = 0; my = 0; e_top = 0; e_mid = 0; e_btm = 0; e_x = 0; e_y = 0;
        end else if (v) begin
            x = fs ? 0 : mx;
            y = fs ? 0 : my;
            img[y][x] = p;
            if (x >= 2 && y >= 2) begin
                e_valid = 1;
                e_top = {img[y-2][x], img[y-2][x-1], img[y-2][x-2]};
                e_mid = {img[y-1][x], img[y-1][x-1], img[y-1][x-2]};
                e_btm = {img[y][x],   img[y][x-1],   img[y][x-2]};
                e_x = x - 1; e_y = y - 1;
                e_done = (x == W-1) && (y == H-1);
            end
            mx = (x == W-1) ? 0 : x + 1;
            my = (x == W-1) ? ((y == H-1) ? 0 : y + 1) : y;
        end
    endtask

    task automatic step(input bit v, input bit fs, input logic [7:0] p, input bit r = 1);
        rst_n = r; pix_valid = v; frame_start = fs; pix_in = p;
        @(posedge clk);
        model(r, v, fs, p);
        #1;
    endtask

    // Raster indices [from, to) of a frame, with pixel = row*16 + col + off.
    task automatic run_px(input int from, input int to, input bit fs_first, input logic [7:0] off);
        for (int i = from; i < to; i++)
            step(1, fs_first && i == from && i == 0, 8'((i / W) * 16 + (i % W)) + off);
    endtask

    task automatic chk_win(input string nm, input int x, input int y,
                           input logic [23:0] t, input logic [23:0] m, input logic [23:0] b);
        chk({nm, "_valid"}, win_valid, 1);
        chk({nm, "_x"}, win_x, x);
        chk({nm, "_y"}, win_y, y);
        chk({nm, "_top"}, win_top, t);
        chk({nm, "_mid"}, win_mid, m);
        chk({nm, "_btm"}, win_btm, b);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                if (win_valid) nwin++;
                chk("cyc_valid", win_valid, e_valid);
                chk("cyc_done", frame_done, e_done);
                chk("cyc_top", win_top, e_top);
                chk("cyc_mid", win_mid, e_mid);
                chk("cyc_btm", win_btm, e_btm);
                chk("cyc_x", win_x, e_x);
                chk("cyc_y", win_y, e_y);
            end
        end
    end

    initial begin
        int n0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        cmp_en = 1;
        chk("rst_valid", win_valid, 0);
        chk("rst_mid", win_mid, 0);

        // Continuous frame with frame_start.
        n0 = nwin;
        run_px(0, 19, 1, 0);
        chk_win("first", 1, 1, 24'h020100, 24'h121110, 24'h222120);
        chk("model_first_mid", e_mid, 24'h121110);
        run_px(19, 48, 1, 0);
        chk("last_done", frame_done, 1);
        chk("last_x", win_x, 6);
        chk("last_y", win_y, 4);
        chk("last_mid", win_mid, 24'h474645);
        @(negedge clk);
        chk("frame1_count", nwin - n0, 24);

        // Three-cycle gap after (4,3).
        run_px(0, 29, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 8'hEE);
            chk("gap_valid", win_valid, 0);
            chk("gap_x", win_x, 3);
            chk("gap_y", win_y, 2);
        end
        run_px(29, 30, 0, 0);
        chk("gap_resume_x", win_x, 4);
        chk("gap_resume_y", win_y, 2);
        chk("gap_resume_mid", win_mid, 24'h252423);
        run_px(30, 48, 0, 0);

        // Back-to-back frame without frame_start.
        @(negedge clk);
        n0 = nwin;
        run_px(0, 18, 0, 0);
        @(negedge clk);
        chk("f2_rows01_none", nwin - n0, 0);
        run_px(18, 19, 0, 0);
        chk_win("f2_first", 1, 1, 24'h020100, 24'h121110, 24'h222120);
        run_px(19, 48, 0, 0);
        @(negedge clk);
        chk("frame2_count", nwin - n0, 24);

        // frame_start where (3,3) would have been; new frame uses different pixel values.
        run_px(0, 27, 1, 0);
        @(negedge clk);
        n0 = nwin;
        run_px(0, 18, 1, 8'h80);
        @(negedge clk);
        chk("restart_none", nwin - n0, 0);
        run_px(18, 19, 0, 8'h80);
        chk_win("restart_first", 1, 1, 24'h828180, 24'h929190, 24'hA2A1A0);
        run_px(19, 48, 0, 8'h80);

        // Reset mid-frame, then a stream without frame_start.
        run_px(0, 21, 1, 0);
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 0, 0);
            chk("rst_mid_valid", win_valid, 0);
            chk("rst_mid_top", win_top, 0);
            chk("rst_mid_x", win_x, 0);
            chk("rst_mid_done", frame_done, 0);
        end
        @(negedge clk);
        n0 = nwin;
        run_px(0, 19, 0, 0);
        chk_win("post_rst_first", 1, 1, 24'h020100, 24'h121110, 24'h222120);
        run_px(19, 48, 0, 0);
        chk("post_rst_done", frame_done, 1);
        @(negedge clk);
        chk("post_rst_count", nwin - n0, 24);

        // Isolated centre pixel of 100 at (4,3).
        for (int i = 0; i < W*H; i++) begin
            step(1, i == 0, (i == 3*W + 4) ? 8'd100 : 8'd0);
            if (i == 4*W + 5) chk_win("corner", 4, 3, 24'h0, 24'h006400, 24'h0);
        end

        // Random pixels, random gaps and occasional frame restarts.
        for (int k = 0; k < 400; k++) begin
            logic v, fs;
            v  = ($urandom_range(0, 3) != 0);
            fs = v && ($urandom_range(0, 79) == 0);
            step(v, fs, 8'($urandom));
        end
        step(0, 0, 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
